adc_spi_master: RTL and testbench
=================================

# adc_spi_master

SPI master that reads a MAX19777-style 12-bit serial ADC, the read-side counterpart of the ADC emulator used in our SDR front end. It generates nCS and SCLK from the system clock and shifts in the 16-bit DOUT frame: a leading zero, 12 data bits MSB first, two trailing zeros, then high-Z. It presents each decoded sample with a one-cycle valid strobe. Frames run back-to-back while enabled, so the block sets the ADC sample rate.

## Interface
- CLK_DIV, 1: CLK cycles per SCLK half-period (≥1); SCLK = CLK/(2·CLK_DIV).
- QUIET_CYCLES, 1: CLK cycles nCS is held high between frames (≥1).
- CLK  in  1  system clock; all logic on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- en  in  1  run frames continuously while high.
- DOUT  in  1  ADC serial data; changes after SCLK falling edges.
- nCS  out  1  ADC chip select, active-low; falling edge = sampling instant.
- SCLK  out  1  ADC serial clock, idles high.
- sample  out  12  last received conversion result.
- sample_valid  out  1  one-cycle strobe: sample updated.
- frame_err  out  1  one-cycle strobe with sample_valid: framing bits wrong.
- busy  out  1  high from SETUP entry to end of QUIET.

## Operation
- Outputs, both registered: nCS and SCLK.
- Reset values: nCS=1, SCLK=1, sample=0, sample_valid=0, frame_err=0, busy=0, state IDLE, all counters 0.
- States:
  - IDLE: nCS=1, SCLK=1. Go to SETUP on the first cycle en is high.
  - SETUP: nCS=0, SCLK=1 for CLK_DIV cycles. Then LOW with bit index 1.
  - LOW: SCLK=0 for CLK_DIV cycles. Then HIGH.
  - HIGH: SCLK=1 for CLK_DIV cycles. If index<16: index+1, go to LOW. If index=16: go to QUIET.
  - QUIET: nCS=1, SCLK=1 for QUIET_CYCLES cycles. Then SETUP if en is high, else IDLE.
- Capture: DOUT is sampled on the CLK edge that drives SCLK 0→1 (end of LOW), into 15-bit shift register sr, shifting left.
  - Rising edge 1 captures the leading zero.
  - Edges 2–13 capture D11..D0.
  - Edges 14–15 capture the trailing zeros.
  - Edge 16 (high-Z) is clocked but not captured.
- On QUIET entry:
  - sample ← sr[13:2], sample_valid=1 for exactly that cycle.
  - frame_err=1 that same cycle if sr[14]≠0 or sr[1:0]≠0.
- en low mid-frame: the current frame completes with its valid strobe, then IDLE. Frames are never truncated.
- nRST low at any point: immediate return to reset values (nCS=1, SCLK=1 asynchronously). The partial frame is discarded and no strobe is issued.
- sample holds its value until the next valid strobe.

## Timing
- Frame length: CLK_DIV (SETUP) + 32·CLK_DIV (16 SCLK periods) + QUIET_CYCLES.
  - Default: 1+32+1 = 34 CLK cycles.
- SCLK has exactly 16 falling edges per nCS-low window, and nCS rises only after the 16th rising edge. This satisfies the "CS high after 10th falling edge" and "resample after 16th clock" rules.
- nCS falls CLK_DIV cycles before the first SCLK falling edge.
- Sample latency: sample_valid is asserted in the CLK cycle after the edge that drives the 16th SCLK rising edge.
  - Default: cycle 34 counted from the SETUP entry edge = 1.
- With en held high, consecutive sample_valid strobes are exactly one frame length apart.
- IDLE→SETUP adds one CLK cycle of en detection latency. busy rises with nCS.
- DOUT must be stable for the full LOW phase. With CLK_DIV=1, slave clock-to-out must be below one CLK period.

## Test plan
- Default parameters, en=1, DOUT driven by the counting ADC emulator from reset (first frame 0x001): sample_valid every 34 cycles with sample=0x001, 0x002, 0x003; frame_err=0; 16 SCLK falls per frame.
- Emulator preloaded to 0xFFE, run three frames: samples 0xFFF, 0x000, 0x001 (wrap); no frame_err.
- DOUT forced to 1: sample=0xFFF, frame_err=1 on the same cycle as sample_valid. DOUT forced to 0: sample=0x000, frame_err=0.
- CLK_DIV=3, QUIET_CYCLES=4: SCLK half-period 3 cycles, nCS high 4 cycles between frames, frame length 3+96+4=103 cycles, correct emulator values.
- en dropped at SCLK edge 5 of a frame: the frame finishes, one valid strobe, then nCS/SCLK stay high and busy=0. en raised again: SETUP begins one cycle later.
- nRST pulsed low mid-frame (after edge 8): nCS=1 and SCLK=1 immediately, no sample_valid, sample unchanged. After release with en=1, the next full frame decodes correctly.

Source files
------------

// File: rtl/adc_spi_master.sv
// SPI master for a MAX19777-style 12-bit ADC: runs back-to-back 16-clock frames while
// enabled and presents each decoded conversion with a one-cycle valid strobe.
module adc_spi_master #(
    parameter int CLK_DIV      = 1,
    parameter int QUIET_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic        DOUT,
    output logic        nCS,
    output logic        SCLK,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int CMAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, QUIET} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    idx_q, idx_d;
    logic [14:0]   sr_q, sr_d;
    logic [11:0]   sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          ncs_q, ncs_d;
    logic          sclk_q, sclk_d;
    logic          busy_q, busy_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sr_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ncs_q    <= 1'b1;
            sclk_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sr_q     <= sr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ncs_q    <= ncs_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        sr_d     = sr_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) state_d = SETUP;
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    idx_d   = 5'd1;
                end
            end
            LOW: begin
                // Edge 16 only clocks the ADC back to high-Z; its DOUT is not data.
                if (cnt_q == DIV_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (idx_q != 5'd16) sr_d = {sr_q[13:0], DOUT};
                end
            end
            HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 5'd16) begin
                        state_d  = QUIET;
                        sample_d = sr_q[13:2];
                        valid_d  = 1'b1;
                        err_d    = sr_q[14] | (|sr_q[1:0]);
                    end else begin
                        state_d = LOW;
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d   = '0;
                    state_d = en ? SETUP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Pin levels are registered from the next state so they switch with it.
        ncs_d  = !(state_d == SETUP || state_d == LOW || state_d == HIGH);
        sclk_d = (state_d != LOW);
        busy_d = (state_d != IDLE);
    end

    assign nCS          = ncs_q;
    assign SCLK         = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Directed bench for adc_spi_master: two instances (default and CLK_DIV=3/QUIET=4),
// each fed by a counting ADC emulator that shifts DOUT after SCLK falling edges.
`timescale 1ns/1ps
module tb_adc_spi_master;
    logic        CLK = 1'b0, nRST = 1'b0, en0 = 1'b0, en1 = 1'b0;
    logic [1:0]  ncs_w, sclk_w, dout_w;
    logic [11:0] sample0, sample1;
    logic        sv0, sv1, fe0, fe1, busy0, busy1;
    logic [11:0] emu_base [2];
    int          emu_mode [2];
    int          cyc = 0, total = 0, bad = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    adc_spi_master #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut0 (
        .CLK(CLK), .nRST(nRST), .en(en0), .DOUT(dout_w[0]), .nCS(ncs_w[0]), .SCLK(sclk_w[0]),
        .sample(sample0), .sample_valid(sv0), .frame_err(fe0), .busy(busy0));

    adc_spi_master #(.CLK_DIV(3), .QUIET_CYCLES(4)) dut1 (
        .CLK(CLK), .nRST(nRST), .en(en1), .DOUT(dout_w[1]), .nCS(ncs_w[1]), .SCLK(sclk_w[1]),
        .sample(sample1), .sample_valid(sv1), .frame_err(fe1), .busy(busy1));

    // Counting ADC: each nCS fall starts a conversion of base+nconv; frame bit 0 models a pulled-up high-Z.
    for (genvar g = 0; g < 2; g++) begin : emu
        logic        ncs_q = 1'b1, sclk_q = 1'b1;
        logic [15:0] frame = 16'hFFFF;
        int          nconv = 0, nfall = 0, lowrun = 0;
        logic [3:0]  fidx;
        always @(ncs_w[g] or sclk_w[g]) begin
            if (ncs_q && !ncs_w[g]) begin
                nconv = nconv + 1;
                frame = {1'b0, 12'(emu_base[g] + 12'(nconv)), 2'b00, 1'b1};
                nfall = 0;
            end else if (sclk_q && !sclk_w[g] && !ncs_w[g]) begin
                nfall = nfall + 1;
            end
            ncs_q  = ncs_w[g];
            sclk_q = sclk_w[g];
        end
        always @(posedge CLK) begin
            if (ncs_w[g]) lowrun <= 0;
            else if (!sclk_w[g]) lowrun <= lowrun + 1;
        end
        assign fidx      = (nfall < 2) ? 4'd15 : 4'(16 - nfall);
        assign dout_w[g] = (emu_mode[g] == 1) ? 1'b1 : (emu_mode[g] == 2) ? 1'b0 : frame[fidx];
    end

    task automatic apply_reset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic set_first(input int g, input logic [11:0] v);
        emu_base[g] = 12'(v - 12'((g == 0) ? emu[0].nconv : emu[1].nconv) - 12'd1);
    endtask

    task automatic wait_valid(input int g, input int limit, output logic found, output int at);
        found = 1'b0;
        at    = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge CLK);
            if ((g == 0) ? sv0 : sv1) begin
                found = 1'b1;
                at    = cyc;
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; en0 = 1'b0; en1 = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (ncs_w[0] !== 1'b1) begin bad++; $display("FAIL reset_ncs: got %b want 1", ncs_w[0]); end
        total++; if (sclk_w[0] !== 1'b1) begin bad++; $display("FAIL reset_sclk: got %b want 1", sclk_w[0]); end
        total++; if (sample0 !== 12'h000) begin bad++; $display("FAIL reset_sample: got %h want 000", sample0); end
        total++; if (sv0 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sv0); end
        total++; if (fe0 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", fe0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
        total++; if ({ncs_w[1], sclk_w[1], busy1} !== 3'b110) begin bad++; $display("FAIL reset_dut1_pins: got %b want 110", {ncs_w[1], sclk_w[1], busy1}); end
        nRST = 1'b1;
        repeat (5) @(negedge CLK);
        total++; if ({ncs_w[0], busy0} !== 2'b10) begin bad++; $display("FAIL idle_no_en: got %b want 10", {ncs_w[0], busy0}); end
    endtask

    task automatic test_count();
        int t0, at; logic f;
        apply_reset();
        emu_mode[0] = 0;
        set_first(0, 12'h001);
        en0 = 1'b1; t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_valid(0, 100, f, at);
            total++; if (!f) begin bad++; $display("FAIL count_timeout: frame %0d got no strobe want strobe in 100 cycles", k); end
            total++; if (at - t0 !== 34) begin bad++; $display("FAIL count_period: frame %0d got %0d want 34", k, at - t0); end
            t0 = at;
            total++; if (sample0 !== 12'(k + 1)) begin bad++; $display("FAIL count_sample: frame %0d got %h want %h", k, sample0, 12'(k + 1)); end
            total++; if (fe0 !== 1'b0) begin bad++; $display("FAIL count_err: frame %0d got %b want 0", k, fe0); end
            total++; if (emu[0].nfall != 16) begin bad++; $display("FAIL count_falls: frame %0d got %0d want 16", k, emu[0].nfall); end
            total++; if (emu[0].lowrun != 16) begin bad++; $display("FAIL count_lowcycles: frame %0d got %0d want 16", k, emu[0].lowrun); end
        end
        en0 = 1'b0;
        repeat (40) @(negedge CLK);
    endtask

    task automatic test_wrap();
        int at; logic f;
        logic [11:0] exp_s [3];
        exp_s[0] = 12'hFFF; exp_s[1] = 12'h000; exp_s[2] = 12'h001;
        set_first(0, 12'hFFF);
        en0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(0, 100, f, at);
            total++; if (!f) begin bad++; $display("FAIL wrap_timeout: frame %0d got no strobe want strobe", k); end
            total++; if (sample0 !== exp_s[k]) begin bad++; $display("FAIL wrap_sample: frame %0d got %h want %h", k, sample0, exp_s[k]); end
            total++; if (fe0 !== 1'b0) begin bad++; $display("FAIL wrap_err: frame %0d got %b want 0", k, fe0); end
        end
        en0 = 1'b0;
        repeat (40) @(negedge CLK);
    endtask

    task automatic test_force();
        int at; logic f;
        int          modes [2];
        logic [11:0] exp_s [2];
        logic        exp_e [2];
        modes[0] = 1; exp_s[0] = 12'hFFF; exp_e[0] = 1'b1;
        modes[1] = 2; exp_s[1] = 12'h000; exp_e[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            emu_mode[0] = modes[k];
            en0 = 1'b1;
            wait_valid(0, 100, f, at);
            total++; if (!f) begin bad++; $display("FAIL force_timeout: mode %0d got no strobe want strobe", modes[k]); end
            total++; if (sample0 !== exp_s[k]) begin bad++; $display("FAIL force_sample: mode %0d got %h want %h", modes[k], sample0, exp_s[k]); end
            total++; if (fe0 !== exp_e[k]) begin bad++; $display("FAIL force_err: mode %0d got %b want %b", modes[k], fe0, exp_e[k]); end
            en0 = 1'b0;
            repeat (40) @(negedge CLK);
        end
        emu_mode[0] = 0;
    endtask

    task automatic test_div3();
        int t0, at, qc; logic f;
        apply_reset();
        set_first(1, 12'h001);
        en1 = 1'b1; t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_valid(1, 300, f, at);
            total++; if (!f) begin bad++; $display("FAIL div3_timeout: frame %0d got no strobe want strobe", k); end
            total++; if (at - t0 !== ((k == 0) ? 100 : 103)) begin bad++; $display("FAIL div3_period: frame %0d got %0d want %0d", k, at - t0, (k == 0) ? 100 : 103); end
            t0 = at;
            total++; if (sample1 !== 12'(k + 1)) begin bad++; $display("FAIL div3_sample: frame %0d got %h want %h", k, sample1, 12'(k + 1)); end
            total++; if (fe1 !== 1'b0) begin bad++; $display("FAIL div3_err: frame %0d got %b want 0", k, fe1); end
            total++; if (emu[1].nfall != 16) begin bad++; $display("FAIL div3_falls: frame %0d got %0d want 16", k, emu[1].nfall); end
            total++; if (emu[1].lowrun != 48) begin bad++; $display("FAIL div3_lowcycles: frame %0d got %0d want 48", k, emu[1].lowrun); end
            if (k == 2) begin
                en1 = 1'b0;
            end else begin
                qc = 1;
                for (int i = 0; i < 10 && ncs_w[1]; i++) begin
                    @(negedge CLK);
                    if (ncs_w[1]) qc++;
                end
                total++; if (qc != 4) begin bad++; $display("FAIL div3_quiet: frame %0d got %0d want 4", k, qc); end
            end
        end
        repeat (40) @(negedge CLK);
    endtask

    task automatic test_en_drop();
        int at, n; logic f, hit;
        apply_reset();
        set_first(0, 12'h123);
        en0 = 1'b1; hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge CLK);
            hit = !ncs_w[0] && (emu[0].nfall == 5);
        end
        total++; if (!hit) begin bad++; $display("FAIL drop_edge5: got no 5th fall want 5th fall in 100 cycles"); end
        en0 = 1'b0;
        wait_valid(0, 100, f, at);
        total++; if (!f) begin bad++; $display("FAIL drop_timeout: got no strobe want strobe"); end
        total++; if (sample0 !== 12'h123) begin bad++; $display("FAIL drop_sample: got %h want 123", sample0); end
        n = 0;
        repeat (50) begin @(negedge CLK); if (sv0) n++; end
        total++; if (n != 0) begin bad++; $display("FAIL drop_extra_strobe: got %0d want 0", n); end
        total++; if ({ncs_w[0], sclk_w[0], busy0} !== 3'b110) begin bad++; $display("FAIL drop_idle_pins: got %b want 110", {ncs_w[0], sclk_w[0], busy0}); end
        en0 = 1'b1;
        @(negedge CLK);
        total++; if ({ncs_w[0], busy0} !== 2'b01) begin bad++; $display("FAIL drop_restart: got %b want 01", {ncs_w[0], busy0}); end
        en0 = 1'b0;
        repeat (60) @(negedge CLK);
    endtask

    task automatic test_rst_mid();
        int t0, at; logic f, hit, seen;
        apply_reset();
        set_first(0, 12'h5A5);
        en0 = 1'b1; hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge CLK);
            hit = !ncs_w[0] && (emu[0].nfall == 9);
        end
        total++; if (!hit) begin bad++; $display("FAIL rst_edge9: got no 9th fall want 9th fall in 100 cycles"); end
        nRST = 1'b0;
        #1;
        total++; if ({ncs_w[0], sclk_w[0], busy0} !== 3'b110) begin bad++; $display("FAIL rst_async_pins: got %b want 110", {ncs_w[0], sclk_w[0], busy0}); end
        total++; if (sample0 !== 12'h000) begin bad++; $display("FAIL rst_sample: got %h want 000", sample0); end
        seen = 1'b0;
        repeat (3) begin @(negedge CLK); seen = seen | sv0; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_strobe: got %b want 0", seen); end
        nRST = 1'b1; t0 = cyc;
        wait_valid(0, 100, f, at);
        total++; if (!f) begin bad++; $display("FAIL rst_timeout: got no strobe want strobe"); end
        total++; if (at - t0 !== 34) begin bad++; $display("FAIL rst_latency: got %0d want 34", at - t0); end
        total++; if (sample0 !== 12'h5A6) begin bad++; $display("FAIL rst_sample_after: got %h want 5a6", sample0); end
        total++; if (fe0 !== 1'b0) begin bad++; $display("FAIL rst_err_after: got %b want 0", fe0); end
        en0 = 1'b0;
        repeat (40) @(negedge CLK);
    endtask

    initial begin
        emu_base[0] = '0; emu_base[1] = '0;
        emu_mode[0] = 0;  emu_mode[1] = 0;
        test_reset();
        test_count();
        test_wrap();
        test_force();
        test_div3();
        test_en_drop();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got no end of run want end before 200us");
        $fatal(1);
    end
endmodule
